// File: rtl/crop_norm_pkg.sv
// Shared types and sizing helpers for the crop/normalise frame sequencer.
package crop_norm_pkg;

  localparam int unsigned FRAME_CNT_W = 16;

  localparam int unsigned DEF_IN_ROWS  = 20;
  localparam int unsigned DEF_IN_COLS  = 20;
  localparam int unsigned DEF_OUT_ROWS = 10;
  localparam int unsigned DEF_OUT_COLS = 10;

  // Counter/coordinate width for a dimension of n pixels, never below 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_COL_W = cnt_w(DEF_IN_COLS);
  localparam int unsigned DEF_ROW_W = cnt_w(DEF_IN_ROWS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_START,
    ST_RUN,
    ST_WAIT_DONE
  } ctrl_state_t;

endpackage

// File: rtl/crop_norm_ctrl_raster_counter.sv
// Raster column/row position of the next accepted pixel, with wrap and a
// combinational flag marking the final pixel of the frame.
module raster_counter
  import crop_norm_pkg::*;
#(
  parameter  int unsigned IN_ROWS = DEF_IN_ROWS,
  parameter  int unsigned IN_COLS = DEF_IN_COLS,
  localparam int unsigned CW      = cnt_w(IN_COLS),
  localparam int unsigned RW      = cnt_w(IN_ROWS)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == CW'(IN_COLS - 1));
  assign row_end = (row == RW'(IN_ROWS - 1));
  assign last    = col_end && row_end;

  // NOTE: non-blocking assignments make col and row both sample pre-edge values.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/crop_norm_ctrl.sv
// Frame-level sequencer for crop_norm: latches/range-checks the crop box,
// runs the ap_start/ap_ready/ap_done handshake and tracks raster position.
// Optional macro CROP_NORM_CTRL_CLAMP_EN clamps an out-of-range box instead of
// abandoning the frame.
module crop_norm_ctrl
  import crop_norm_pkg::*;
#(
  parameter  int unsigned IN_ROWS  = DEF_IN_ROWS,
  parameter  int unsigned IN_COLS  = DEF_IN_COLS,
  parameter  int unsigned OUT_ROWS = DEF_OUT_ROWS,
  parameter  int unsigned OUT_COLS = DEF_OUT_COLS,
  localparam int unsigned CW       = cnt_w(IN_COLS),
  localparam int unsigned RW       = cnt_w(IN_ROWS)
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   ctrl_enable,
  input  logic                   ctrl_continuous,
  input  logic [CW-1:0]          host_crop_x0,
  input  logic [RW-1:0]          host_crop_y0,
  input  logic                   beat,
  input  logic                   cn_ap_ready,
  input  logic                   cn_ap_done,
  output logic                   ap_start,
  output logic [CW-1:0]          crop_x0,
  output logic [RW-1:0]          crop_y0,
  output logic [CW-1:0]          cnt_col,
  output logic [RW-1:0]          cnt_row,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   err_coord,
  output logic                   err_stray
);

  ctrl_state_t state;
  logic        en_q;
  logic        rise_q;
  logic        done_pend;

  // Range check one bit wider than the coordinates so the sum never wraps.
  logic [CW:0] x_sum;
  logic [RW:0] y_sum;
  logic        x_bad;
  logic        y_bad;

  assign x_sum = {1'b0, host_crop_x0} + (CW+1)'(OUT_COLS);
  assign y_sum = {1'b0, host_crop_y0} + (RW+1)'(OUT_ROWS);
  assign x_bad = x_sum > (CW+1)'(IN_COLS);
  assign y_bad = y_sum > (RW+1)'(IN_ROWS);

  logic cnt_clear;
  logic cnt_advance;
  logic cnt_last;

  assign cnt_clear   = !ctrl_enable || (state == ST_LATCH);
  assign cnt_advance = ctrl_enable && (state == ST_RUN) && beat;

  raster_counter #(
    .IN_ROWS (IN_ROWS),
    .IN_COLS (IN_COLS)
  ) u_raster (
    .clk     (clk),
    .srst    (srst),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .col     (cnt_col),
    .row     (cnt_row),
    .last    (cnt_last)
  );

  // NOTE: reset is synchronous, so srst is simply the top-priority branch here.
  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= ST_IDLE;
      en_q        <= 1'b0;
      rise_q      <= 1'b0;
      done_pend   <= 1'b0;
      ap_start    <= 1'b0;
      crop_x0     <= '0;
      crop_y0     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_coord   <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      en_q       <= ctrl_enable;
      rise_q     <= ctrl_enable && !en_q;
      frame_done <= 1'b0;

      if (rise_q) begin
        err_coord <= 1'b0;
        err_stray <= 1'b0;
      end
      if (beat && (state != ST_RUN)) err_stray <= 1'b1;

      // Dropping the enable aborts from any state, including on the last beat.
      if (!ctrl_enable) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        ap_start  <= 1'b0;
        done_pend <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (ctrl_continuous || rise_q) begin
              state <= ST_LATCH;
              busy  <= 1'b1;
            end
          end

          ST_LATCH: begin
            done_pend <= 1'b0;
            crop_x0   <= host_crop_x0;
            crop_y0   <= host_crop_y0;
            if (x_bad || y_bad) err_coord <= 1'b1;
`ifdef CROP_NORM_CTRL_CLAMP_EN
            if (x_bad) crop_x0 <= CW'(IN_COLS - OUT_COLS);
            if (y_bad) crop_y0 <= RW'(IN_ROWS - OUT_ROWS);
            state    <= ST_START;
            ap_start <= 1'b1;
`else
            if (x_bad || y_bad) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= ST_START;
              ap_start <= 1'b1;
            end
`endif
          end

          ST_START: begin
            if (cn_ap_ready) begin
              state    <= ST_RUN;
              ap_start <= 1'b0;
            end
          end

          ST_RUN: begin
            // An early ap_done is held until the last pixel has been accepted.
            if (cn_ap_done) done_pend <= 1'b1;
            if (beat && cnt_last) state <= ST_WAIT_DONE;
          end

          ST_WAIT_DONE: begin
            if (cn_ap_done || done_pend) begin
              done_pend   <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + FRAME_CNT_W'(1);
              if (ctrl_continuous) begin
                state <= ST_LATCH;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
